fir_coef_loader: RTL and testbench

//   Drives the serial coefficient-load interface of the DW_fir filter (coef_shift_en / coef_in) and

---
 rtl/fir_coef_loader_pkg.sv | 17 +
 rtl/fir_coef_loader_if.sv | 13 +
 rtl/fir_coef_loader_shadow.sv | 26 ++
 rtl/fir_coef_loader.sv | 167 ++++++++++++++++
 tb/tb_fir_coef_loader.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_coef_loader_pkg.sv
// Shared definitions for the DW_fir coefficient loader: FSM states and counter sizing.
package fir_coef_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_VERIFY,
    ST_DONE
  } state_t;

  // Width of a tap index counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_coef_loader_if.sv
// Coefficient packet stream between the register/DMA source and the loader.
interface fir_coef_if #(
  parameter int coef_width = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [coef_width-1:0] s_coef;
  logic                  s_last;
  logic                  verify_en;

  modport master (output s_valid, s_coef, s_last, verify_en, input s_ready);
  modport slave  (input s_valid, s_coef, s_last, verify_en, output s_ready);
endinterface

// File: rtl/fir_coef_loader_shadow.sv
// Shadow copy of the coefficients last shifted into the filter; read back during verify.
module fir_coef_shadow #(
  parameter int coef_width = 8,
  parameter int order      = 6,
  parameter int aw         = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [aw-1:0]         wr_addr,
  input  logic [coef_width-1:0] wr_data,
  input  logic [aw-1:0]         rd_addr,
  output logic [coef_width-1:0] rd_data
);

  logic [coef_width-1:0] shadow_reg [order];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      shadow_reg[wr_addr] <= wr_data;
    end
  end

  // Combinational read so the verify word reaches coef_in one cycle after its index.
  assign rd_data = shadow_reg[rd_addr];

endmodule

// File: rtl/fir_coef_loader.sv
// Shifts one coefficient packet into the DW_fir serial load chain, then optionally
// re-shifts the shadow copy while comparing the chain tail (verify-and-repair).
module fir_coef_loader
  import fir_coef_pkg::*;
#(
  parameter int coef_width = 8,
  parameter int order      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fir_coef_if.slave             s,
  output logic                  coef_shift_en,
  output logic [coef_width-1:0] coef_in,
  input  logic [coef_width-1:0] coef_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len,
  output logic                  err_mismatch
);

  localparam int              CW       = cnt_width(order);
  localparam logic [CW-1:0]   LAST_IDX = CW'(order - 1);

  state_t                state_reg, state_next;
  logic [CW-1:0]         k_reg, k_next, j_reg, j_next;
  logic                  verify_reg, verify_next;
  logic                  shift_reg, shift_next;
  logic                  vshift_reg, vshift_next;
  logic                  done_reg, done_next;
  logic                  err_len_reg, err_len_next;
  logic                  err_mm_reg, err_mm_next;
  logic [coef_width-1:0] coef_reg, coef_next;
  logic [coef_width-1:0] rd_data;
  logic                  wr_en;
  logic                  xfer;

  // Ready is forced low while reset is asserted so no word is taken mid-reset.
  assign s.s_ready = rst_n & ((state_reg == ST_IDLE) || (state_reg == ST_LOAD) ||
                              (state_reg == ST_FLUSH));
  assign xfer      = s.s_valid & s.s_ready;

  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    j_next       = j_reg;
    verify_next  = verify_reg;
    shift_next   = 1'b0;
    vshift_next  = 1'b0;
    coef_next    = coef_reg;
    done_next    = (state_reg == ST_DONE);
    err_len_next = err_len_reg;
    err_mm_next  = err_mm_reg;
    wr_en        = 1'b0;

    // The word now on coef_in during a verify shift should equal the chain tail.
    if (vshift_reg && (coef_out != coef_reg)) begin
      err_mm_next = 1'b1;
    end

    unique case (state_reg)
      ST_IDLE: begin
        if (xfer) begin
          wr_en        = 1'b1;
          shift_next   = 1'b1;
          coef_next    = s.s_coef;
          verify_next  = s.verify_en;
          err_mm_next  = 1'b0;
          err_len_next = s.s_last;
          k_next       = s.s_last ? '0 : CW'(1);
          state_next   = s.s_last ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          wr_en      = 1'b1;
          shift_next = 1'b1;
          coef_next  = s.s_coef;
          if (k_reg == LAST_IDX) begin
            k_next = '0;
            if (s.s_last) begin
              state_next = verify_reg ? ST_VERIFY : ST_DONE;
            end else begin
              err_len_next = 1'b1;
              state_next   = ST_FLUSH;
            end
          end else if (s.s_last) begin
            k_next       = '0;
            err_len_next = 1'b1;
            state_next   = ST_DONE;
          end else begin
            k_next = k_reg + CW'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (xfer && s.s_last) begin
          state_next = ST_DONE;
        end
      end
      ST_VERIFY: begin
        shift_next  = 1'b1;
        vshift_next = 1'b1;
        coef_next   = rd_data;
        if (j_reg == LAST_IDX) begin
          j_next     = '0;
          state_next = ST_DONE;
        end else begin
          j_next = j_reg + CW'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      k_reg       <= '0;
      j_reg       <= '0;
      verify_reg  <= 1'b0;
      shift_reg   <= 1'b0;
      vshift_reg  <= 1'b0;
      coef_reg    <= '0;
      done_reg    <= 1'b0;
      err_len_reg <= 1'b0;
      err_mm_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      k_reg       <= k_next;
      j_reg       <= j_next;
      verify_reg  <= verify_next;
      shift_reg   <= shift_next;
      vshift_reg  <= vshift_next;
      coef_reg    <= coef_next;
      done_reg    <= done_next;
      err_len_reg <= err_len_next;
      err_mm_reg  <= err_mm_next;
    end
  end

  fir_coef_shadow #(
    .coef_width (coef_width),
    .order      (order),
    .aw         (CW)
  ) u_shadow (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (k_reg),
    .wr_data (s.s_coef),
    .rd_addr (j_reg),
    .rd_data (rd_data)
  );

  assign coef_shift_en = shift_reg;
  assign coef_in       = coef_reg;
  assign done          = done_reg;
  assign err_len       = err_len_reg;
  assign err_mismatch  = err_mm_reg;
  assign busy          = (state_reg == ST_LOAD) || (state_reg == ST_FLUSH) ||
                         (state_reg == ST_VERIFY);

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed + randomized packets against a behavioural model of the DW_fir coefficient chain.
module tb_fir_coef_loader;

  localparam int ORDER = 6;
  localparam int W     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_coef_if #(.coef_width(W)) bus ();

  logic         coef_shift_en, busy, done, err_len, err_mismatch;
  logic [W-1:0] coef_in, coef_out;

  fir_coef_loader #(.coef_width(W), .order(ORDER)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s             (bus.slave),
    .coef_shift_en (coef_shift_en),
    .coef_in       (coef_in),
    .coef_out      (coef_out),
    .busy          (busy),
    .done          (done),
    .err_len       (err_len),
    .err_mismatch  (err_mismatch)
  );

  // Filter coefficient chain: chain[0] is the entry tap, chain[ORDER-1] the tail.
  logic [W-1:0] chain [ORDER] = '{default: '0};
  int           cyc           = 0;
  int           shift_cyc[$];
  logic [W-1:0] shift_val[$];
  int           corrupt_req   = 0;
  int           corrupt_ack   = 0;
  int           vectors       = 0;
  int           miscompares   = 0;

  assign coef_out = chain[ORDER-1];

  always @(posedge clk) begin
    if (coef_shift_en) begin
      for (int i = ORDER - 1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= coef_in;
      shift_cyc.push_back(cyc);
      shift_val.push_back(coef_in);
    end
    // Corrupt coefficient c3, which sits at chain[ORDER-1-3] once a full set is loaded.
    if (corrupt_req != corrupt_ack) begin
      chain[ORDER-1-3] <= 8'hFF;
      corrupt_ack      <= corrupt_req;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the word transferred.
  task automatic put_word(input logic [W-1:0] w, input logic last, input logic ven);
    int n = 0;
    bus.s_valid   = 1'b1;
    bus.s_coef    = w;
    bus.s_last    = last;
    bus.verify_en = ven;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) chk("ready_timeout", 32'(bus.s_ready), 32'(1));
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int dcyc, output logic gl, output logic gm);
    seen = 1'b0; dcyc = 0; gl = 1'b0; gm = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (done) begin
        seen = 1'b1; dcyc = cyc; gl = err_len; gm = err_mismatch;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_result(input logic [W-1:0] w[$], input bit ven, input bit corrupt,
                              input bit b2b, input int t0, input int base,
                              input logic [W-1:0] prior [ORDER], input bit seen,
                              input int dcyc, input logic gl, input logic gm);
    int           len   = w.size();
    int           nload = (len < ORDER) ? len : ORDER;
    bit           full  = (len == ORDER);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model [ORDER];
    for (int i = 0; i < nload; i++) exp_q.push_back(w[i]);
    if (full && ven) for (int i = 0; i < ORDER; i++) exp_q.push_back(w[i]);
    chk("done_seen", 32'(seen), 32'(1));
    chk("err_len", 32'(gl), 32'(!full));
    chk("err_mismatch", 32'(gm), 32'(full && ven && corrupt));
    chk("shift_count", 32'(shift_val.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < shift_val.size(); i++) begin
      chk("shift_val", 32'(shift_val[base+i]), 32'(exp_q[i]));
      if (b2b) chk("shift_cyc", 32'(shift_cyc[base+i] - t0), 32'(i + 1));
    end
    if (b2b && len <= ORDER) chk("done_cyc", 32'(dcyc - t0), 32'(exp_q.size() + 1));
    for (int i = 0; i < ORDER; i++) model[i] = prior[i];
    foreach (exp_q[e]) begin
      for (int i = ORDER - 1; i > 0; i--) model[i] = model[i-1];
      model[0] = exp_q[e];
    end
    for (int i = 0; i < ORDER; i++) chk("chain_tap", 32'(chain[i]), 32'(model[i]));
  endtask

  task automatic run_packet(input logic [W-1:0] w[$], input bit ven, input bit corrupt,
                            input bit gap);
    logic [W-1:0] prior [ORDER];
    int           base, t0, dcyc;
    bit           seen;
    logic         gl, gm;
    for (int i = 0; i < ORDER; i++) prior[i] = chain[i];
    base = shift_val.size();
    t0   = cyc;
    for (int i = 0; i < w.size(); i++) begin
      put_word(w[i], (i == w.size() - 1), ven);
      if (gap && i < w.size() - 1) @(negedge clk);
    end
    if (corrupt) corrupt_req++;
    wait_done(seen, dcyc, gl, gm);
    @(negedge clk);
    check_result(w, ven, corrupt, !gap, t0, base, prior, seen, dcyc, gl, gm);
  endtask

  task automatic check_reset_outputs();
    chk("rst_shift_en", 32'(coef_shift_en), 32'(0));
    chk("rst_coef_in", 32'(coef_in), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err_len", 32'(err_len), 32'(0));
    chk("rst_err_mm", 32'(err_mismatch), 32'(0));
    chk("rst_ready", 32'(bus.s_ready), 32'(0));
  endtask

  function automatic void rand_words(output logic [W-1:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(W'($urandom_range(0, 255)));
  endfunction

  initial begin
    logic [W-1:0] w[$];
    logic [W-1:0] prior [ORDER];
    logic [W-1:0] x;
    int           base, n, dcyc;
    bit           seen;
    logic         gl, gm;

    bus.s_valid = 1'b0; bus.s_coef = '0; bus.s_last = 1'b0; bus.verify_en = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    #1 chk("ready_after_reset", 32'(bus.s_ready), 32'(1));
    @(negedge clk);

    w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_packet(w, 1'b0, 1'b0, 1'b0);
    run_packet(w, 1'b1, 1'b0, 1'b0);
    run_packet(w, 1'b1, 1'b1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      rand_words(w, ORDER);
      run_packet(w, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    rand_words(w, 3);
    run_packet(w, 1'b1, 1'b0, 1'b0);
    rand_words(w, 8);
    run_packet(w, 1'b1, 1'b0, 1'b0);

    // Gapped verify packet, with the next packet's word held against s_ready=0.
    rand_words(w, ORDER);
    for (int i = 0; i < ORDER; i++) prior[i] = chain[i];
    base = shift_val.size();
    for (int i = 0; i < ORDER; i++) begin
      put_word(w[i], (i == ORDER - 1), 1'b1);
      if (i < ORDER - 1) @(negedge clk);
    end
    chk("ready_in_verify", 32'(bus.s_ready), 32'(0));
    chk("busy_in_verify", 32'(busy), 32'(1));
    x = W'($urandom_range(0, 255));
    bus.s_valid = 1'b1; bus.s_coef = x; bus.s_last = 1'b1; bus.verify_en = 1'b0;
    seen = 1'b0; gl = 1'b0; gm = 1'b0; n = 0;
    while (n < 40) begin
      if (done && !seen) begin seen = 1'b1; gl = err_len; gm = err_mismatch; end
      if (bus.s_ready) break;
      @(negedge clk);
      n++;
    end
    chk("stall_cycles", 32'(n), 32'(ORDER + 1));
    check_result(w, 1'b1, 1'b0, 1'b0, 0, base, prior, seen, 0, gl, gm);
    for (int i = 0; i < ORDER; i++) prior[i] = chain[i];
    base = shift_val.size();
    @(negedge clk);
    bus.s_valid = 1'b0;
    wait_done(seen, dcyc, gl, gm);
    @(negedge clk);
    w = '{x};
    check_result(w, 1'b0, 1'b0, 1'b0, 0, base, prior, seen, dcyc, gl, gm);

    // Reset in the middle of a load, then a clean packet.
    rand_words(w, 3);
    for (int i = 0; i < 3; i++) put_word(w[i], 1'b0, 1'b1);
    rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_midreset", 32'(bus.s_ready), 32'(1));
    @(negedge clk);
    rand_words(w, ORDER);
    run_packet(w, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
